fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
// - Controller for the instruction-fetch stage.
// - Loads a program word-by-word into program memory through the address mux.
// - Then runs the program in continuous or single-step mode, driving the PC enable and NOP injection.
// - Detects the HALT word and freezes fetch.
// - Sits between the debug/UART unit and the IF top; owns all IF memory and mux control.
// PARAMETERS
// CANT_BITS_ADDR  11            program memory address width
// RAM_WIDTH       32            instruction width
// HALT_WORD       32'hFFFFFFFF  instruction word that stops execution
// PORTS
// i_clock                  in   1   system clock, rising edge
// i_soft_reset             in   1   asynchronous reset, active-low
// i_load_valid             in   1   load word offered (valid/ready handshake)
// i_load_data              in   RAM_WIDTH  program word to store
// i_load_last              in   1   qualifies final word of program
// o_load_ready             out  1   sequencer accepts load word this cycle
// i_run_mode               in   1   0 = continuous, 1 = step; sampled on i_start
// i_start                  in   1   pulse: leave READY and begin execution
// i_step                   in   1   pulse: execute one fetch in step mode
// i_stall                  in   1   hazard stall from decode; hold PC
// i_flush                  in   1   branch taken; replace fetched word by NOP
// i_instruction            in   RAM_WIDTH  raw word read from program memory
// o_enable_contador_PC     out  1   PC register enable
// o_enable_mem             out  1   program memory enable
// o_write_read_mem         out  1   1 = write program memory
// o_addr_mem_programa      out  CANT_BITS_ADDR  load address
// o_data_mem_programa      out  RAM_WIDTH  load data
// o_control_mux_addr_mem   out  1   1 = memory addressed by loader, 0 = by PC
// o_control_mux_ouput      out  1   1 = IF outputs NOP
// o_halt                   out  1   HALT reached
// o_load_overflow          out  1   load exceeded 2**CANT_BITS_ADDR words
// o_estado                 out  3   current state code
// o_cant_ciclos            out  32  cycles spent executing
// BEHAVIOUR
// - Reset (async, any state): state IDLE; all outputs 0 except o_control_mux_ouput = 1.
// - Reset clears load address, counters and flags; memory contents untouched.
// - States:
//   - IDLE: exits to LOAD on the first i_load_valid.
//   - LOAD: o_load_ready = 1; o_control_mux_addr_mem = 1.
//     - Accepted word is registered; one cycle later o_enable_mem = 1, o_write_read_mem = 1, with address/data of that word.
//     - Load address increments per accepted word, starting at 0.
//     - After the write of the i_load_last word -> READY.
//     - Acceptance at address 2**CANT_BITS_ADDR-1 without last: write it, set o_load_overflow (sticky), -> READY.
//   - READY: o_control_mux_addr_mem = 0, o_enable_mem = 1, write = 0, NOP = 1.
//     - i_start -> RUN (i_run_mode = 0) or STEP_WAIT (i_run_mode = 1).
//   - RUN: o_enable_contador_PC = ~i_stall & ~halt_det; o_control_mux_ouput = i_flush | halt_det.
//     - o_cant_ciclos increments every cycle in RUN.
//   - STEP_WAIT: PC disabled, NOP = 1. i_step -> STEP_EXEC.
//   - STEP_EXEC: same outputs as RUN.
//     - -> STEP_WAIT in the first cycle with ~i_stall; stays while stalled.
//     - o_cant_ciclos increments every cycle in STEP_EXEC.
//   - HALT: PC disabled, NOP = 1, o_halt = 1. Terminal until reset.
// - halt_det = (i_instruction == HALT_WORD) & ~i_flush & ~i_stall, evaluated in RUN/STEP_EXEC only.
//   - It gates the PC combinationally in the same cycle; next state = HALT.
// - Priorities: flush > halt (squashed HALT ignored); stall > step completion; i_start/i_step outside their states ignored.
// - i_load_valid in any state other than IDLE/LOAD ignored (o_load_ready = 0).
// - o_cant_ciclos saturates at 32'hFFFFFFFF.
// STRUCTURE
// - fetch_sequencer_defs.vh: state localparams IDLE=0, LOAD=1, READY=2, RUN=3, STEP_WAIT=4, STEP_EXEC=5, HALT=6.
// - Same include file: NOP word 32'h00210824.
// - No sub-module: next-state logic, load counter and write register live in one module.
// TESTING
// - Reset mid-LOAD after 3 words -> state IDLE, o_load_ready = 0, NOP = 1; reload restarts at addr 0.
// - Load 4 words (last on 4th) -> writes at addr 0..3 one cycle after each accept; then READY, o_load_overflow = 0.
// - Load 2048 words without last -> o_load_overflow = 1 after addr 2047 write; state READY.
// - Continuous run, i_stall high 2 cycles -> PC enable low exactly those 2 cycles; o_cant_ciclos still counts.
// - HALT_WORD fetched with i_flush = 1 -> no halt; next HALT_WORD with no flush -> PC enable 0 that cycle, o_halt = 1 next.
// - Step mode: 3 i_step pulses, one with stall -> PC advances exactly 3 times; NOP = 1 in STEP_WAIT.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding and
// the NOP word that the IF output mux substitutes when NOP injection is active.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_READY     = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP_WAIT = 3'd4,
    ST_STEP_EXEC = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  localparam logic [31:0] NOP_WORD   = 32'h0021_0824;
  localparam logic [31:0] CYCLES_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: streams a program into program memory, then
// runs it continuously or one fetch at a time until the HALT word is fetched.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                   CANT_BITS_ADDR = 11,
  parameter int                   RAM_WIDTH      = 32,
  parameter logic [RAM_WIDTH-1:0] HALT_WORD      = {RAM_WIDTH{1'b1}}
) (
  input  logic                      i_clock,
  input  logic                      i_soft_reset,
  input  logic                      i_load_valid,
  input  logic [RAM_WIDTH-1:0]      i_load_data,
  input  logic                      i_load_last,
  output logic                      o_load_ready,
  input  logic                      i_run_mode,
  input  logic                      i_start,
  input  logic                      i_step,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [RAM_WIDTH-1:0]      i_instruction,
  output logic                      o_enable_contador_PC,
  output logic                      o_enable_mem,
  output logic                      o_write_read_mem,
  output logic [CANT_BITS_ADDR-1:0] o_addr_mem_programa,
  output logic [RAM_WIDTH-1:0]      o_data_mem_programa,
  output logic                      o_control_mux_addr_mem,
  output logic                      o_control_mux_ouput,
  output logic                      o_halt,
  output logic                      o_load_overflow,
  output logic [2:0]                o_estado,
  output logic [31:0]               o_cant_ciclos
);

  state_e                      state_q, state_d;
  logic [CANT_BITS_ADDR-1:0]   load_addr_q;
  logic                        wr_valid_q, wr_term_q, wr_ovf_q;
  logic [CANT_BITS_ADDR-1:0]   wr_addr_q;
  logic [RAM_WIDTH-1:0]        wr_data_q;
  logic                        load_ovf_q;
  logic [31:0]                 cycles_q;

  logic load_ready, accept, at_top, halt_det, count_en;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d                = state_q;
    load_ready             = 1'b0;
    o_enable_contador_PC   = 1'b0;
    o_enable_mem           = 1'b0;
    o_write_read_mem       = 1'b0;
    o_control_mux_addr_mem = 1'b0;
    o_control_mux_ouput    = 1'b1;
    o_halt                 = 1'b0;
    halt_det               = 1'b0;
    count_en               = 1'b0;

    unique case (state_q)
      ST_IDLE: if (i_load_valid) state_d = ST_LOAD;
      ST_LOAD: begin
        o_control_mux_addr_mem = 1'b1;
        // Stop accepting once the terminating word is waiting to be written.
        load_ready       = ~(wr_valid_q & wr_term_q);
        o_enable_mem     = wr_valid_q;
        o_write_read_mem = wr_valid_q;
        if (wr_valid_q && wr_term_q) state_d = ST_READY;
      end
      ST_READY: begin
        o_enable_mem = 1'b1;
        if (i_start) state_d = i_run_mode ? ST_STEP_WAIT : ST_RUN;
      end
      ST_RUN, ST_STEP_EXEC: begin
        o_enable_mem         = 1'b1;
        halt_det             = (i_instruction == HALT_WORD) & ~i_flush & ~i_stall;
        o_enable_contador_PC = ~i_stall & ~halt_det;
        o_control_mux_ouput  = i_flush | halt_det;
        count_en             = 1'b1;
        if (halt_det)                                 state_d = ST_HALT;
        else if (state_q == ST_STEP_EXEC && !i_stall) state_d = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        o_enable_mem = 1'b1;
        if (i_step) state_d = ST_STEP_EXEC;
      end
      ST_HALT:  o_halt = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign accept = load_ready & i_load_valid;
  assign at_top = (load_addr_q == {CANT_BITS_ADDR{1'b1}});

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state_q     <= ST_IDLE;
      load_addr_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_term_q   <= 1'b0;
      wr_ovf_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      load_ovf_q  <= 1'b0;
      cycles_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wr_valid_q <= accept;
      if (accept) begin
        wr_addr_q   <= load_addr_q;
        wr_data_q   <= i_load_data;
        wr_term_q   <= i_load_last | at_top;
        wr_ovf_q    <= ~i_load_last & at_top;
        load_addr_q <= load_addr_q + 1'b1;
      end
      if (wr_valid_q && wr_ovf_q) load_ovf_q <= 1'b1;
      if (count_en && cycles_q != CYCLES_MAX) cycles_q <= cycles_q + 32'd1;
    end
  end

  assign o_load_ready        = load_ready;
  assign o_addr_mem_programa = wr_addr_q;
  assign o_data_mem_programa = wr_data_q;
  assign o_load_overflow     = load_ovf_q;
  assign o_estado            = state_q;
  assign o_cant_ciclos       = cycles_q;

endmodule
